sakebi_eth_rx_parser: RTL and testbench
=======================================

# sakebi_eth_rx_parser

Consumes the raw RMII receive byte stream (AXI4-Stream, 8-bit, no TLAST) and turns it into framed Ethernet packets. Per frame it:
- hunts preamble/SFD and extracts the destination MAC, source MAC and EtherType;
- filters on destination address;
- checks CRC32 and length;
- forwards the payload on an AXIS master with TLAST, with the 4-byte FCS stripped.

Frame end is detected by an idle gap on the input stream. The block sits directly downstream of the RMII receiver and upstream of the protocol stages.

## Interface
Parameters:
- IDLE_GAP, 16: consecutive cycles with i_s_axis_TVALID low that end a frame; legal range 2..255.
- MAC_ADDR, 48'h02_00_00_00_00_01: local unicast address.
- PROMISC, 0: 1 disables destination filtering.

Ports:
- i_axis_ACLK  in  1  single clock for the whole block.
- i_axis_ARESET  in  1  asynchronous, active-high reset.
- i_s_axis_TVALID  in  1  byte from RMII receiver valid.
- o_s_axis_TREADY  out  1  byte accepted.
- i_s_axis_TDATA  in  8  received byte.
- o_m_axis_TVALID  out  1  payload byte valid.
- i_m_axis_TREADY  in  1  downstream ready.
- o_m_axis_TDATA  out  8  payload byte.
- o_m_axis_TLAST  out  1  last payload byte of the frame.
- o_m_axis_TUSER  out  1  bad-frame flag; meaningful only with TLAST.
- o_dst_mac  out  48  destination MAC, first byte received in bits [47:40].
- o_src_mac  out  48  source MAC, same byte order.
- o_ethertype  out  16  EtherType, first byte in bits [15:8].
- o_hdr_valid  out  1  one-cycle pulse; header fields are stable until the next pulse.
- o_frame_ok  out  1  one-cycle pulse on a good frame.
- o_frame_err  out  1  one-cycle pulse on a bad frame.

## Operation
- States:
  - IDLE: accepts bytes. 0x55 → PREAMBLE; any other byte → DROP.
  - PREAMBLE: 0x55 stays; 0xD5 → HEADER; anything else → DROP.
  - HEADER: exactly 14 bytes.
    - Bytes 0-5 → dst, 6-11 → src, 12-13 → EtherType.
    - After byte 13: if PROMISC=0 and dst is neither MAC_ADDR nor FF:FF:FF:FF:FF:FF → DROP (silent). Otherwise pulse o_hdr_valid and go to PAYLOAD.
  - PAYLOAD: each accepted byte is pushed into a 6-entry FIFO. When the FIFO holds 6 bytes, the oldest is presented with TLAST=0.
  - LAST: entered on idle gap. Drains (count−4) bytes with TLAST on the final one; the remaining 4 bytes (FCS) are discarded. If count≤4, nothing is emitted. Returns to IDLE.
  - DROP: accepts and discards bytes until idle gap, then → IDLE.
- CRC32: IEEE 802.3 reflected, polynomial 0xEDB88320, init 0xFFFFFFFF. It runs over every byte from dst byte 0 through the last FCS byte. A good frame leaves the register equal to the residue 0xDEBB20E3.
- Length counter: 11-bit, saturating at 2047, counts dst..FCS bytes.
- Bad frame = CRC residue mismatch, or length <64, or length >1518.
- o_s_axis_TREADY:
  - 1 in IDLE/PREAMBLE/HEADER/DROP.
  - 0 in LAST.
  - In PAYLOAD: (count<6) || (o_m_axis_TVALID && i_m_axis_TREADY).
- Idle-gap counter: cleared on every input handshake; increments while i_s_axis_TVALID=0 in any state except IDLE; saturates. Reaching IDLE_GAP ends the frame.
- Gap in PREAMBLE or HEADER → IDLE, no pulses.

## Timing
- Reset: every output is 0, header registers are 0, state is IDLE, FIFO is empty, CRC = 0xFFFFFFFF. Reset mid-frame discards the frame with no pulses.
- o_hdr_valid pulses in the cycle after the 14th header byte handshake.
- Payload latency: byte N appears on the master once byte N+5 has been accepted, i.e. one cycle after that handshake.
- Master holds TDATA/TLAST/TUSER stable while TVALID=1 and TREADY=0. TVALID never depends on TREADY.
- Final byte: TLAST=1, TUSER=bad. o_frame_ok or o_frame_err pulses in the TLAST handshake cycle.
- Good payload-less frame (count≤4 at gap): not possible, because the minimum length check makes it bad.
- Bad payload-less frame (count≤4 at gap): o_frame_err pulses one cycle after entering LAST.
- Filtered frames and DROP frames produce no pulses.
- A new preamble is only recognised after returning to IDLE.

## Structure
- Shared package sakebi_eth_pkg holds:
  - constants: PREAMBLE 8'h55, SFD 8'hD5, CRC_INIT, CRC_POLY, CRC_RESIDUE, MIN_FRAME 64, MAX_FRAME 1518, BROADCAST_MAC;
  - the state encoding.
- Sub-module sakebi_crc32_byte: combinational next-CRC function (32-bit state in, 8-bit data in, 32-bit state out). It is reused later by the TX path.

## Test plan
- Good 64-byte frame to MAC_ADDR (7×55, D5, header, 46-byte payload, correct FCS), TREADY held 1 → 46 payload bytes out; TLAST on byte 46 with TUSER=0; o_frame_ok pulse; o_ethertype = header value; one o_hdr_valid pulse.
- Same frame with one payload bit flipped → 46 bytes out; TLAST with TUSER=1; o_frame_err pulse.
- dst 02:00:00:00:00:99 with PROMISC=0 → no master output, no pulses, no o_hdr_valid. With PROMISC=1 → frame forwarded.
- Broadcast frame with downstream TREADY toggling 1-0 every cycle → identical byte sequence; data stable during stalls; no input bytes lost.
- 40-byte runt with valid CRC → TUSER=1 and o_frame_err. Preamble 55 55 AA … → DROP, no output; a following good frame is received correctly.
- Assert i_axis_ARESET during PAYLOAD → all outputs 0 immediately; the next good frame parses correctly.

Source files
------------

// File: rtl/sakebi_eth_pkg.sv
// Shared Ethernet constants and RX parser state encoding.
package sakebi_eth_pkg;

  localparam logic [7:0]  PREAMBLE      = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [10:0] MIN_FRAME     = 11'd64;
  localparam logic [10:0] MAX_FRAME     = 11'd1518;
  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_LAST,
    ST_DROP
  } rx_state_e;

endpackage

// File: rtl/sakebi_crc32_byte.sv
// Combinational reflected CRC32 update over one byte (LSB first).
module sakebi_crc32_byte
  import sakebi_eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/sakebi_eth_rx_parser.sv
// Ethernet RX parser: preamble hunt, header extraction, address filter,
// CRC/length check, payload forwarding with the FCS stripped.
module sakebi_eth_rx_parser
  import sakebi_eth_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 16,
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC  = 1'b0
) (
  input  logic        i_axis_ACLK,
  input  logic        i_axis_ARESET,
  input  logic        i_s_axis_TVALID,
  output logic        o_s_axis_TREADY,
  input  logic [7:0]  i_s_axis_TDATA,
  output logic        o_m_axis_TVALID,
  input  logic        i_m_axis_TREADY,
  output logic [7:0]  o_m_axis_TDATA,
  output logic        o_m_axis_TLAST,
  output logic        o_m_axis_TUSER,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_ethertype,
  output logic        o_hdr_valid,
  output logic        o_frame_ok,
  output logic        o_frame_err
);

  localparam logic [7:0] GAP_LIM = 8'(IDLE_GAP);

  rx_state_e     state_q, state_d;
  logic [3:0]    hcnt_q, hcnt_d;
  logic [103:0]  sh_q, sh_d;
  logic [47:0]   dst_q, dst_d, src_q, src_d;
  logic [15:0]   type_q, type_d;
  logic          hdr_vld_q, hdr_vld_d;
  logic [31:0]   crc_q, crc_d, crc_nxt;
  logic [10:0]   len_q, len_d, len_inc;
  logic [7:0]    gap_q, gap_d;
  logic [7:0]    fifo_q [6];
  logic [7:0]    fifo_d [6];
  logic [2:0]    cnt_q, cnt_d, wr_idx;

  logic          s_ready, s_hs, m_valid, m_last, m_hs;
  logic          push, pop, gap_hit, bad, dst_pass, ok_p, err_p;
  logic [47:0]   dst_cand;

  sakebi_crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (i_s_axis_TDATA),
    .crc_o  (crc_nxt)
  );

  always_ff @(posedge i_axis_ACLK or posedge i_axis_ARESET) begin
    if (i_axis_ARESET) begin
      state_q   <= ST_IDLE;
      hcnt_q    <= '0;
      sh_q      <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      type_q    <= '0;
      hdr_vld_q <= 1'b0;
      crc_q     <= CRC_INIT;
      len_q     <= '0;
      gap_q     <= '0;
      fifo_q    <= '{default: '0};
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      sh_q      <= sh_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      type_q    <= type_d;
      hdr_vld_q <= hdr_vld_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      fifo_q    <= fifo_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    sh_d      = sh_q;
    dst_d     = dst_q;
    src_d     = src_q;
    type_d    = type_q;
    hdr_vld_d = 1'b0;
    crc_d     = crc_q;
    len_d     = len_q;
    fifo_d    = fifo_q;
    cnt_d     = cnt_q;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    s_ready   = 1'b1;
    push      = 1'b0;
    ok_p      = 1'b0;
    err_p     = 1'b0;

    gap_hit  = (gap_q >= GAP_LIM);
    bad      = (crc_q != CRC_RESIDUE) || (len_q < MIN_FRAME) || (len_q > MAX_FRAME);
    len_inc  = (len_q == '1) ? len_q : len_q + 11'd1;
    dst_cand = sh_q[103:56];
    dst_pass = PROMISC || (dst_cand == MAC_ADDR) || (dst_cand == BROADCAST_MAC);

    case (state_q)
      ST_PAYLOAD: begin
        m_valid = (cnt_q == 3'd6);
        s_ready = (cnt_q < 3'd6) || (m_valid && i_m_axis_TREADY);
      end
      ST_LAST: begin
        m_valid = (cnt_q > 3'd4);
        m_last  = (cnt_q == 3'd5);
        s_ready = 1'b0;
      end
      default: ;
    endcase

    s_hs = i_s_axis_TVALID && s_ready;
    m_hs = m_valid && i_m_axis_TREADY;
    pop  = m_hs;

    if (state_q == ST_IDLE || s_hs)           gap_d = '0;
    else if (!i_s_axis_TVALID && gap_q != '1) gap_d = gap_q + 8'd1;
    else                                      gap_d = gap_q;

    case (state_q)
      ST_IDLE: begin
        crc_d  = CRC_INIT;
        len_d  = '0;
        hcnt_d = '0;
        cnt_d  = '0;
        if (s_hs) state_d = (i_s_axis_TDATA == PREAMBLE) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        crc_d  = CRC_INIT;
        len_d  = '0;
        hcnt_d = '0;
        if (gap_hit) state_d = ST_IDLE;
        else if (s_hs) begin
          if (i_s_axis_TDATA == SFD)           state_d = ST_HEADER;
          else if (i_s_axis_TDATA != PREAMBLE) state_d = ST_DROP;
        end
      end
      ST_HEADER: begin
        if (gap_hit) state_d = ST_IDLE;
        else if (s_hs) begin
          crc_d  = crc_nxt;
          len_d  = len_inc;
          sh_d   = {sh_q[95:0], i_s_axis_TDATA};
          hcnt_d = hcnt_q + 4'd1;
          // Fields are latched only for accepted frames so they hold across filtered ones.
          if (hcnt_q == 4'd13) begin
            if (dst_pass) begin
              dst_d     = sh_q[103:56];
              src_d     = sh_q[55:8];
              type_d    = {sh_q[7:0], i_s_axis_TDATA};
              hdr_vld_d = 1'b1;
              state_d   = ST_PAYLOAD;
            end else begin
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (gap_hit) state_d = ST_LAST;
        else if (s_hs) begin
          crc_d = crc_nxt;
          len_d = len_inc;
          push  = 1'b1;
        end
      end
      ST_LAST: begin
        if (cnt_q <= 3'd4) begin
          ok_p    = !bad;
          err_p   = bad;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (m_hs && m_last) begin
          ok_p    = !bad;
          err_p   = bad;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (gap_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Shift-down FIFO: the head is always entry 0, new bytes land after the last valid entry.
    if (pop) begin
      for (int unsigned i = 0; i < 5; i++) fifo_d[i] = fifo_q[i+1];
    end
    wr_idx = pop ? (cnt_q - 3'd1) : cnt_q;
    if (push) begin
      for (int unsigned i = 0; i < 6; i++) begin
        if (3'(i) == wr_idx) fifo_d[i] = i_s_axis_TDATA;
      end
    end
    if (push != pop) cnt_d = push ? (cnt_q + 3'd1) : (cnt_q - 3'd1);
  end

  always_comb begin
    o_s_axis_TREADY = s_ready;
    o_m_axis_TVALID = m_valid;
    o_m_axis_TDATA  = fifo_q[0];
    o_m_axis_TLAST  = m_last;
    o_m_axis_TUSER  = m_last && bad;
    o_dst_mac       = dst_q;
    o_src_mac       = src_q;
    o_ethertype     = type_q;
    o_hdr_valid     = hdr_vld_q;
    o_frame_ok      = ok_p;
    o_frame_err     = err_p;
  end

endmodule

// File: tb/tb_sakebi_eth_rx_parser.sv
// Directed bench for sakebi_eth_rx_parser with a filtering and a promiscuous instance.
`define CHK(TAG, OBS, EXP) \
  begin \
    n_checks++; \
    assert ((OBS) === (EXP)) n_pass++; \
    else begin \
      n_fail++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_sakebi_eth_rx_parser;

  localparam int unsigned GAP = 8;
  localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC_MAC = 48'h0A_1B_2C_3D_4E_5F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        m_ready = 1'b1;
  logic        toggle = 1'b0;

  logic        s_ready, m_valid, m_last, m_user, hdr_v, f_ok, f_err;
  logic [7:0]  m_data;
  logic [47:0] dst, src;
  logic [15:0] etype;

  logic        p_s_ready, p_valid, p_last, p_user, p_hdr, p_ok, p_err;
  logic [7:0]  p_data;
  logic [47:0] p_dst, p_src;
  logic [15:0] p_etype;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  sakebi_eth_rx_parser #(.IDLE_GAP(GAP), .MAC_ADDR(MY_MAC), .PROMISC(1'b0)) u_dut (
    .i_axis_ACLK(clk), .i_axis_ARESET(rst),
    .i_s_axis_TVALID(s_valid), .o_s_axis_TREADY(s_ready), .i_s_axis_TDATA(s_data),
    .o_m_axis_TVALID(m_valid), .i_m_axis_TREADY(m_ready), .o_m_axis_TDATA(m_data),
    .o_m_axis_TLAST(m_last), .o_m_axis_TUSER(m_user),
    .o_dst_mac(dst), .o_src_mac(src), .o_ethertype(etype),
    .o_hdr_valid(hdr_v), .o_frame_ok(f_ok), .o_frame_err(f_err)
  );

  sakebi_eth_rx_parser #(.IDLE_GAP(GAP), .MAC_ADDR(MY_MAC), .PROMISC(1'b1)) u_prm (
    .i_axis_ACLK(clk), .i_axis_ARESET(rst),
    .i_s_axis_TVALID(s_valid), .o_s_axis_TREADY(p_s_ready), .i_s_axis_TDATA(s_data),
    .o_m_axis_TVALID(p_valid), .i_m_axis_TREADY(m_ready), .o_m_axis_TDATA(p_data),
    .o_m_axis_TLAST(p_last), .o_m_axis_TUSER(p_user),
    .o_dst_mac(p_dst), .o_src_mac(p_src), .o_ethertype(p_etype),
    .o_hdr_valid(p_hdr), .o_frame_ok(p_ok), .o_frame_err(p_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = toggle ? ~m_ready : 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge.
  logic [7:0] out_q[$];
  int   ok_cnt = 0, err_cnt = 0, hdr_cnt = 0, last_cnt = 0, last_pos = 0;
  logic last_user = 1'b0;
  int   stall_err = 0, p_out = 0, p_okc = 0;
  logic st_prev = 1'b0;
  logic [10:0] st_snap = '0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      out_q.push_back(m_data);
      if (m_last) begin
        last_cnt  <= last_cnt + 1;
        last_pos  <= out_q.size();
        last_user <= m_user;
      end
    end
    if (f_ok)  ok_cnt  <= ok_cnt + 1;
    if (f_err) err_cnt <= err_cnt + 1;
    if (hdr_v) hdr_cnt <= hdr_cnt + 1;
    if (st_prev && ({m_valid, m_data, m_last, m_user} !== st_snap)) stall_err <= stall_err + 1;
    st_prev <= m_valid && !m_ready && !rst;
    st_snap <= {m_valid, m_data, m_last, m_user};
    if (p_valid && m_ready) p_out <= p_out + 1;
    if (p_ok) p_okc <= p_okc + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] frm [0:1599];
  int frm_len;

  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  task automatic build_frame(input logic [47:0] d, input logic [15:0] et, input int plen,
                             input logic [7:0] seed);
    logic [31:0] c;
    for (int i = 0; i < 6; i++) begin
      frm[i]   = d[47-8*i -: 8];
      frm[6+i] = SRC_MAC[47-8*i -: 8];
    end
    frm[12] = et[15:8];
    frm[13] = et[7:0];
    for (int j = 0; j < plen; j++) frm[14+j] = 8'(j * 13) + seed;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < 14 + plen; k++) c = crc_bits(c, frm[k]);
    c = ~c;
    for (int k = 0; k < 4; k++) frm[14+plen+k] = c[8*k +: 8];
    frm_len = 18 + plen;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: tready observed 0, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pre();
    repeat (7) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  task automatic send_body();
    for (int k = 0; k < frm_len; k++) send_byte(frm[k]);
  endtask

  int ob, okb, errb, hdrb, lastb, stb, pob, pokb;
  logic [13:0] obs;

  task automatic snap();
    ob = out_q.size(); okb = ok_cnt; errb = err_cnt; hdrb = hdr_cnt;
    lastb = last_cnt; stb = stall_err; pob = p_out; pokb = p_okc;
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {m_valid, m_data, m_last, m_user, hdr_v, f_ok, f_err};
    `CHK("reset_outputs", obs, 14'h0)
    `CHK("reset_headers", {dst, src, etype}, 112'h0)
    rst = 1'b0;
    idle(3);

    // Good 64-byte frame, with header pulse and payload latency timing
    build_frame(MY_MAC, 16'h0800, 46, 8'h11);
    snap();
    send_pre();
    for (int k = 0; k < frm_len; k++) begin
      send_byte(frm[k]);
      if (k == 13) begin
        `CHK("hdr_pulse", hdr_v, 1'b1)
        `CHK("ethertype", etype, 16'h0800)
        `CHK("dst_mac", dst, MY_MAC)
        `CHK("src_mac", src, SRC_MAC)
      end
      if (k == 18) `CHK("lat_not_yet", m_valid, 1'b0)
      if (k == 19) begin
        `CHK("lat_valid", m_valid, 1'b1)
        `CHK("lat_data", m_data, frm[14])
      end
    end
    idle(GAP + 30);
    `CHK("good_count", out_q.size() - ob, 46)
    for (int j = 0; j < 46; j++) `CHK("good_data", out_q[ob+j], frm[14+j])
    `CHK("good_tlast_cnt", last_cnt - lastb, 1)
    `CHK("good_tlast_pos", last_pos, ob + 46)
    `CHK("good_tuser", last_user, 1'b0)
    `CHK("good_ok", ok_cnt - okb, 1)
    `CHK("good_err", err_cnt - errb, 0)
    `CHK("good_hdr_cnt", hdr_cnt - hdrb, 1)

    // Same frame, one payload bit flipped
    build_frame(MY_MAC, 16'h0800, 46, 8'h11);
    frm[20] = frm[20] ^ 8'h04;
    snap();
    send_pre();
    send_body();
    idle(GAP + 30);
    `CHK("crc_count", out_q.size() - ob, 46)
    `CHK("crc_tuser", last_user, 1'b1)
    `CHK("crc_err", err_cnt - errb, 1)
    `CHK("crc_ok", ok_cnt - okb, 0)

    // Foreign unicast: filtered by u_dut, forwarded by u_prm
    build_frame(48'h02_00_00_00_00_99, 16'h0806, 46, 8'h33);
    snap();
    send_pre();
    send_body();
    idle(GAP + 30);
    `CHK("filt_count", out_q.size() - ob, 0)
    `CHK("filt_pulses", (ok_cnt - okb) + (err_cnt - errb), 0)
    `CHK("filt_hdr", hdr_cnt - hdrb, 0)
    `CHK("filt_hdr_hold", etype, 16'h0800)
    `CHK("prm_count", p_out - pob, 46)
    `CHK("prm_ok", p_okc - pokb, 1)

    // Broadcast with downstream ready toggling every cycle
    build_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 46, 8'h5A);
    snap();
    toggle = 1'b1;
    send_pre();
    send_body();
    idle(GAP + 40);
    toggle = 1'b0;
    idle(2);
    `CHK("bc_count", out_q.size() - ob, 46)
    for (int j = 0; j < 46; j++) `CHK("bc_data", out_q[ob+j], frm[14+j])
    `CHK("bc_stable", stall_err - stb, 0)
    `CHK("bc_ok", ok_cnt - okb, 1)
    `CHK("bc_ethertype", etype, 16'h88B5)

    // 40-byte runt with valid CRC
    build_frame(MY_MAC, 16'h0800, 22, 8'h77);
    snap();
    send_pre();
    send_body();
    idle(GAP + 30);
    `CHK("runt_count", out_q.size() - ob, 22)
    `CHK("runt_tuser", last_user, 1'b1)
    `CHK("runt_err", err_cnt - errb, 1)
    `CHK("runt_ok", ok_cnt - okb, 0)

    // Broken preamble, then a good frame
    build_frame(MY_MAC, 16'h0800, 46, 8'h21);
    snap();
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_body();
    idle(GAP + 30);
    `CHK("badpre_count", out_q.size() - ob, 0)
    `CHK("badpre_pulses", (ok_cnt - okb) + (err_cnt - errb) + (hdr_cnt - hdrb), 0)
    snap();
    send_pre();
    send_body();
    idle(GAP + 30);
    `CHK("after_count", out_q.size() - ob, 46)
    for (int j = 0; j < 46; j++) `CHK("after_data", out_q[ob+j], frm[14+j])
    `CHK("after_ok", ok_cnt - okb, 1)

    // Reset in the middle of the payload
    build_frame(MY_MAC, 16'h0800, 46, 8'h42);
    send_pre();
    for (int k = 0; k < 34; k++) send_byte(frm[k]);
    s_valid = 1'b0;
    `CHK("pre_rst_valid", m_valid, 1'b1)
    snap();
    rst = 1'b1;
    #1;
    obs = {m_valid, m_data, m_last, m_user, hdr_v, f_ok, f_err};
    `CHK("midrst_outputs", obs, 14'h0)
    `CHK("midrst_headers", {dst, src, etype}, 112'h0)
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(GAP + 10);
    `CHK("midrst_pulses", (ok_cnt - okb) + (err_cnt - errb), 0)
    build_frame(MY_MAC, 16'h0800, 46, 8'h63);
    snap();
    send_pre();
    send_body();
    idle(GAP + 30);
    `CHK("post_rst_count", out_q.size() - ob, 46)
    for (int j = 0; j < 46; j++) `CHK("post_rst_data", out_q[ob+j], frm[14+j])
    `CHK("post_rst_ok", ok_cnt - okb, 1)
    `CHK("post_rst_tuser", last_user, 1'b0)

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
